// File: rtl/prefetch_unit.sv
// Instruction prefetch front end: one outstanding ROM request, DEPTH-entry FIFO, jump flush.
// Optional same-cycle bypass of ROM data to inst_* when PREFETCH_BYPASS_EN is defined.
module prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_en_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            hold_flag_i,
    output logic            rom_req_o,
    output logic [XLEN-1:0] rom_addr_o,
    input  logic            rom_rvalid_i,
    input  logic [XLEN-1:0] rom_inst_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_addr_o
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_addr_q [DEPTH];

    logic            head_valid, rsp_live, bypass, pop, fifo_pop, push, issue;
    logic [AW:0]     count_after;

    always_comb begin
        head_valid = (count_q != '0);
        rsp_live   = rst && (state_q == S_WAIT) && rom_rvalid_i;
`ifdef PREFETCH_BYPASS_EN
        bypass     = rsp_live && !head_valid && !jump_en_i;
`else
        bypass     = 1'b0;
`endif
        inst_valid_o = head_valid || bypass;
        inst_o       = NOP;
        inst_addr_o  = '0;
        if (head_valid) begin
            inst_o      = fifo_data_q[rd_ptr_q[AW-1:0]];
            inst_addr_o = fifo_addr_q[rd_ptr_q[AW-1:0]];
        end else if (bypass) begin
            inst_o      = rom_inst_i;
            inst_addr_o = req_addr_q;
        end

        pop      = inst_valid_o && !hold_flag_i && !jump_en_i;
        fifo_pop = pop && head_valid;
        // A bypassed word that is consumed never touches the FIFO.
        push     = rsp_live && !jump_en_i && !(bypass && pop);
        count_after = count_q - {{AW{1'b0}}, fifo_pop} + {{AW{1'b0}}, push};

        // The new request's response needs a free slot once this cycle's pop/push settle.
        issue = rst && !jump_en_i && ((state_q == S_FETCH) || rsp_live) && (count_after < DEPTH_C);

        rom_req_o  = issue;
        rom_addr_o = fetch_pc_q;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
        count_d    = count_after;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            req_addr_d = fetch_pc_q;
        end

        if (jump_en_i) begin
            fetch_pc_d = jump_addr_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            case (state_q)
                S_WAIT:  state_d = rom_rvalid_i ? S_FETCH : S_DROP;
                S_DROP:  state_d = rom_rvalid_i ? S_FETCH : S_DROP;
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: if (issue) state_d = S_WAIT;
                S_WAIT:  if (rom_rvalid_i) state_d = issue ? S_WAIT : S_FETCH;
                S_DROP:  if (rom_rvalid_i) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q[AW-1:0]] <= rom_inst_i;
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit (default build) with a variable-latency ROM model returning addr as data.
module tb_prefetch_unit;

    logic        clk, rst, jump_en, hold;
    logic [31:0] jump_addr;
    logic        rom_req, rom_rvalid, inst_valid;
    logic [31:0] rom_addr, rom_inst, inst, inst_addr;
    logic        rom_req_w, rom_rvalid_w, inst_valid_w;
    logic [31:0] rom_addr_w, rom_inst_w, inst_w, inst_addr_w;

    int checks = 0;
    int errors = 0;
    int rom_lat = 1;

    prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_flag_i(hold),
        .rom_req_o(rom_req), .rom_addr_o(rom_addr), .rom_rvalid_i(rom_rvalid), .rom_inst_i(rom_inst),
        .inst_valid_o(inst_valid), .inst_o(inst), .inst_addr_o(inst_addr));

    prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .jump_en_i(jump_en), .jump_addr_i(jump_addr), .hold_flag_i(hold),
        .rom_req_o(rom_req_w), .rom_addr_o(rom_addr_w), .rom_rvalid_i(rom_rvalid_w), .rom_inst_i(rom_inst_w),
        .inst_valid_o(inst_valid_w), .inst_o(inst_w), .inst_addr_o(inst_addr_w));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: response rom_lat cycles after the request, data = address.
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    always @(posedge clk) begin
        if (!rst) begin
            pend       <= 1'b0;
            rom_rvalid <= 1'b0;
            cnt        <= 0;
        end else begin
            rom_rvalid <= 1'b0;
            if (rom_req) begin
                if (rom_lat == 1) begin
                    rom_rvalid <= 1'b1;
                    rom_inst   <= rom_addr;
                end else begin
                    pend      <= 1'b1;
                    pend_addr <= rom_addr;
                    cnt       <= rom_lat - 1;
                end
            end else if (pend) begin
                if (cnt == 1) begin
                    rom_rvalid <= 1'b1;
                    rom_inst   <= pend_addr;
                    pend       <= 1'b0;
                end
                cnt <= cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        rom_rvalid_w <= rst ? rom_req_w : 1'b0;
        rom_inst_w   <= rom_addr_w;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; jump_en = 1'b0; hold = 1'b0; jump_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; jump_en = 1'b0; hold = 1'b0; jump_addr = '0;
        #1;
        checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_req_low: got %b exp 0", rom_req); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", inst_valid); end
        checks++; if (inst !== 32'h13) begin errors++; $display("FAIL reset_inst: got %h exp 00000013", inst); end
        checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_inst_addr: got %h exp 0", inst_addr); end
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr: got %h exp 0", rom_addr); end
        checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b exp 1", rom_req); end
    endtask

    task automatic test_stream();
        rom_lat = 1;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            checks++; if (rom_req !== 1'b1 || rom_addr !== 32'(4*c))
                begin errors++; $display("FAIL stream_req c%0d: got %b/%h exp 1/%h", c, rom_req, rom_addr, 32'(4*c)); end
            if (c < 2) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d: got %b exp 0", c, inst_valid); end
            end else begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'(4*(c-2)) || inst !== 32'(4*(c-2)))
                    begin errors++; $display("FAIL stream_inst c%0d: got %b/%h/%h exp 1/%h", c, inst_valid, inst_addr, inst, 32'(4*(c-2))); end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_hold();
        rom_lat = 1;
        do_reset();
        hold = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (rom_req !== (c < 4))
                begin errors++; $display("FAIL hold_req c%0d: got %b exp %b", c, rom_req, (c < 4)); end
            if (c == 9) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0)
                    begin errors++; $display("FAIL hold_head: got %b/%h exp 1/0", inst_valid, inst_addr); end
            end
            @(negedge clk); #1;
        end
        hold = 1'b0;
        #1;
        for (int j = 0; j < 5; j++) begin
            if (j == 0) begin
                checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h10)
                    begin errors++; $display("FAIL hold_resume_req: got %b/%h exp 1/00000010", rom_req, rom_addr); end
            end
            checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'(4*j))
                begin errors++; $display("FAIL hold_drain j%0d: got %b/%h exp 1/%h", j, inst_valid, inst_addr, 32'(4*j)); end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_jump_drop();
        rom_lat = 3;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            jump_en = (c == 7); jump_addr = 32'h100;
            #1;
            if (c == 6) begin
                checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h8)
                    begin errors++; $display("FAIL drop_req8: got %b/%h exp 1/00000008", rom_req, rom_addr); end
            end
            if (c >= 7 && c <= 9) begin
                checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL drop_no_req c%0d: got %b exp 0", c, rom_req); end
            end
            if (c == 10) begin
                checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h100)
                    begin errors++; $display("FAIL drop_target_req: got %b/%h exp 1/00000100", rom_req, rom_addr); end
            end
            if (c >= 8 && c <= 13) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_empty c%0d: got %b exp 0", c, inst_valid); end
            end
            if (c == 14) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h100)
                    begin errors++; $display("FAIL drop_first_target: got %b/%h exp 1/00000100", inst_valid, inst_addr); end
            end
            if (c >= 8) begin
                checks++; if (inst_valid === 1'b1 && inst_addr === 32'h8)
                    begin errors++; $display("FAIL drop_stale c%0d: got valid addr %h exp never 00000008", c, inst_addr); end
            end
            @(negedge clk); #1;
        end
        jump_en = 1'b0;
    endtask

    task automatic test_jump_rvalid();
        rom_lat = 1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            jump_en = (c == 3); jump_addr = 32'h200; hold = (c < 4);
            #1;
            if (c == 3) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0)
                    begin errors++; $display("FAIL jr_two_entries: got %b/%h exp 1/0", inst_valid, inst_addr); end
                checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL jr_no_req: got %b exp 0", rom_req); end
            end
            if (c == 4) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jr_flushed: got %b exp 0", inst_valid); end
                checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h200)
                    begin errors++; $display("FAIL jr_target_req: got %b/%h exp 1/00000200", rom_req, rom_addr); end
            end
            if (c == 5) begin
                checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jr_dropped: got %b exp 0", inst_valid); end
            end
            if (c == 6) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h200 || inst !== 32'h200)
                    begin errors++; $display("FAIL jr_target_inst: got %b/%h exp 1/00000200", inst_valid, inst_addr); end
            end
            @(negedge clk); #1;
        end
        jump_en = 1'b0; hold = 1'b0;
    endtask

    task automatic test_midreset();
        rom_lat = 1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            rst = (c != 16);
            #1;
            if (c == 15) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h34)
                    begin errors++; $display("FAIL mr_stream: got %b/%h exp 1/00000034", inst_valid, inst_addr); end
            end
            if (c == 16) begin
                checks++; if (rom_addr !== 32'h40 || rom_req !== 1'b0)
                    begin errors++; $display("FAIL mr_in_reset: got %b/%h exp 0/00000040", rom_req, rom_addr); end
            end
            if (c == 17) begin
                checks++; if (inst_valid !== 1'b0 || inst !== 32'h13 || inst_addr !== 32'h0)
                    begin errors++; $display("FAIL mr_inst_reset: got %b/%h/%h exp 0/00000013/0", inst_valid, inst, inst_addr); end
                checks++; if (rom_req !== 1'b1 || rom_addr !== 32'h0)
                    begin errors++; $display("FAIL mr_restart: got %b/%h exp 1/0", rom_req, rom_addr); end
            end
            if (c == 19) begin
                checks++; if (inst_valid !== 1'b1 || inst_addr !== 32'h0)
                    begin errors++; $display("FAIL mr_first_inst: got %b/%h exp 1/0", inst_valid, inst_addr); end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] wexp [4];
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++; if (rom_req_w !== 1'b1 || rom_addr_w !== wexp[c])
                begin errors++; $display("FAIL wrap_addr c%0d: got %b/%h exp 1/%h", c, rom_req_w, rom_addr_w, wexp[c]); end
            if (c == 2) begin
                checks++; if (inst_valid_w !== 1'b1 || inst_addr_w !== 32'hFFFF_FFF8)
                    begin errors++; $display("FAIL wrap_inst: got %b/%h exp 1/fffffff8", inst_valid_w, inst_addr_w); end
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; jump_en = 1'b0; hold = 1'b0; jump_addr = '0;
        test_reset();
        test_stream();
        test_hold();
        test_jump_drop();
        test_jump_rvalid();
        test_midreset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
